// File: rtl/conv_pkg.sv
// Shared definitions for the convolution / dense layer family.
//   sm_word_t    : sign-magnitude word at the default 35-bit width (bit 34 = sign)
//   conv_state_t : sequencer states
//   out_dim()    : output extent of a strided, padded convolution along one axis
//   addr_w()     : index width for a given depth (never narrower than 1 bit)
package conv_pkg;

    localparam int unsigned SmWidth = 35;

    typedef logic [SmWidth-1:0] sm_word_t;

    typedef enum logic [2:0] {
        StIdle,
        StBias,
        StMac,
        StDrain,
        StEmit,
        StDone
    } conv_state_t;

    function automatic int unsigned out_dim(input int unsigned in_dim, input int unsigned k,
                                            input int unsigned stride, input int unsigned pad);
        return (in_dim + 2 * pad - k) / stride + 1;
    endfunction

    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sm_mac.sv
// Sign-magnitude multiply-accumulate with a registered accumulator.
//   clock, reset : rising-edge clock, synchronous active-high reset (clears acc)
//   load         : replace acc with load_val (negative zero folded to +0)
//   en           : acc <= acc + a*b (sign-magnitude, saturating)
//   a, b         : operands, bit N-1 = sign, Q fractional bits
//   acc          : accumulator, registered
module sm_mac #(
    parameter int unsigned N = 35,
    parameter int unsigned Q = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         en,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] acc
);

    localparam int unsigned M  = N - 1;
    localparam int unsigned PW = 2 * M;

    logic [PW-1:0] prod_full;
    logic [PW-1:0] prod_shift;
    logic [M-1:0]  p_mag;
    logic          p_sgn;
    logic [M-1:0]  acc_mag;
    logic [M:0]    sum_wide;
    logic [M-1:0]  res_mag;
    logic          res_sgn;
    logic [N-1:0]  acc_d;

    always_comb begin
        prod_full  = PW'(a[M-1:0]) * PW'(b[M-1:0]);
        prod_shift = prod_full >> Q;
        // A product too large for the magnitude field clamps rather than wraps.
        p_mag      = (|prod_shift[PW-1:M]) ? '1 : prod_shift[M-1:0];
        p_sgn      = (p_mag != '0) && (a[M] ^ b[M]);

        acc_mag    = acc[M-1:0];
        sum_wide   = {1'b0, acc_mag} + {1'b0, p_mag};

        if (acc[M] == p_sgn) begin
            res_mag = sum_wide[M] ? '1 : sum_wide[M-1:0];
            res_sgn = acc[M];
        end else if (acc_mag >= p_mag) begin
            res_mag = acc_mag - p_mag;
            res_sgn = acc[M];
        end else begin
            res_mag = p_mag - acc_mag;
            res_sgn = p_sgn;
        end
        if (res_mag == '0) begin
            res_sgn = 1'b0;
        end

        acc_d = acc;
        if (load) begin
            acc_d = {load_val[M] && (load_val[M-1:0] != '0), load_val[M-1:0]};
        end else if (en) begin
            acc_d = {res_sgn, res_mag};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc <= '0;
        end else begin
            acc <= acc_d;
        end
    end

endmodule

// File: rtl/conv2d_seq.sv
// Sequential 2-D convolution: one output at a time, one tap per cycle, from
// synchronous-read memories (data valid one cycle after address).
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   go / busy / flag      : start pulse, frame in progress, one-cycle done pulse
//   in_addr / in_data     : input feature read port (channel-major)
//   w_addr / w_data       : weight read port
//   bias_addr / bias_data : bias read port
//   out_valid / out_ready : result handshake
//   out_data, out_ch, out_row, out_col : result word and its coordinates
module conv2d_seq
    import conv_pkg::*;
#(
    parameter int unsigned N       = 35,
    parameter int unsigned Q       = 32,
    parameter int unsigned IC      = 4,
    parameter int unsigned OC      = 8,
    parameter int unsigned H       = 64,
    parameter int unsigned W       = 64,
    parameter int unsigned K       = 5,
    parameter int unsigned STRIDE  = 2,
    parameter int unsigned PAD     = 2,
    localparam int unsigned OH     = out_dim(H, K, STRIDE, PAD),
    localparam int unsigned OW     = out_dim(W, K, STRIDE, PAD),
    localparam int unsigned InAw   = addr_w(IC * H * W),
    localparam int unsigned WAw    = addr_w(OC * IC * K * K),
    localparam int unsigned ChW    = addr_w(OC),
    localparam int unsigned RowW   = addr_w(OH),
    localparam int unsigned ColW   = addr_w(OW)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            go,
    output logic            busy,
    output logic            flag,
    output logic [InAw-1:0] in_addr,
    input  logic [N-1:0]    in_data,
    output logic [WAw-1:0]  w_addr,
    input  logic [N-1:0]    w_data,
    output logic [ChW-1:0]  bias_addr,
    input  logic [N-1:0]    bias_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_data,
    output logic [ChW-1:0]  out_ch,
    output logic [RowW-1:0] out_row,
    output logic [ColW-1:0] out_col
);

    localparam int unsigned IcW = addr_w(IC);
    localparam int unsigned KW  = addr_w(K);

    localparam logic [KW-1:0]   KLast   = KW'(K - 1);
    localparam logic [IcW-1:0]  IcLast  = IcW'(IC - 1);
    localparam logic [ChW-1:0]  OcLast  = ChW'(OC - 1);
    localparam logic [RowW-1:0] OhLast  = RowW'(OH - 1);
    localparam logic [ColW-1:0] OwLast  = ColW'(OW - 1);

    conv_state_t     state_q, state_d;
    logic [ChW-1:0]  oc_q, oc_d;
    logic [RowW-1:0] oh_q, oh_d;
    logic [ColW-1:0] ow_q, ow_d;
    logic [IcW-1:0]  ic_q, ic_d;
    logic [KW-1:0]   kr_q, kr_d;
    logic [KW-1:0]   kc_q, kc_d;

    // Control delayed by the one-cycle memory read latency.
    logic            bias_load_q;
    logic            tap_en_q;

    int              r_pos;
    int              c_pos;
    logic            tap_in_range;
    logic [N-1:0]    acc;

    // Tap position and read addresses.
    always_comb begin
        r_pos        = int'(oh_q) * int'(STRIDE) + int'(kr_q) - int'(PAD);
        c_pos        = int'(ow_q) * int'(STRIDE) + int'(kc_q) - int'(PAD);
        tap_in_range = (r_pos >= 0) && (r_pos < int'(H)) && (c_pos >= 0) && (c_pos < int'(W));

        in_addr   = '0;
        w_addr    = '0;
        bias_addr = '0;
        if (state_q == StMac) begin
            w_addr = WAw'(((int'(oc_q) * int'(IC) + int'(ic_q)) * int'(K) + int'(kr_q)) * int'(K)
                          + int'(kc_q));
            if (tap_in_range) begin
                in_addr = InAw'((int'(ic_q) * int'(H) + r_pos) * int'(W) + c_pos);
            end
        end
        if (state_q == StBias) begin
            bias_addr = oc_q;
        end
    end

    // Next state, counters and handshake outputs.
    always_comb begin
        state_d   = state_q;
        oc_d      = oc_q;
        oh_d      = oh_q;
        ow_d      = ow_q;
        ic_d      = ic_q;
        kr_d      = kr_q;
        kc_d      = kc_q;
        busy      = 1'b0;
        flag      = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (go) begin
                    state_d = StBias;
                    oc_d    = '0;
                    oh_d    = '0;
                    ow_d    = '0;
                end
            end
            StBias: begin
                busy    = 1'b1;
                ic_d    = '0;
                kr_d    = '0;
                kc_d    = '0;
                state_d = StMac;
            end
            StMac: begin
                busy = 1'b1;
                if (kc_q != KLast) begin
                    kc_d = kc_q + 1'b1;
                end else begin
                    kc_d = '0;
                    if (kr_q != KLast) begin
                        kr_d = kr_q + 1'b1;
                    end else begin
                        kr_d = '0;
                        if (ic_q != IcLast) begin
                            ic_d = ic_q + 1'b1;
                        end else begin
                            ic_d    = '0;
                            state_d = StDrain;
                        end
                    end
                end
            end
            StDrain: begin
                busy    = 1'b1;
                state_d = StEmit;
            end
            StEmit: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StBias;
                    if (ow_q != OwLast) begin
                        ow_d = ow_q + 1'b1;
                    end else begin
                        ow_d = '0;
                        if (oh_q != OhLast) begin
                            oh_d = oh_q + 1'b1;
                        end else begin
                            oh_d = '0;
                            if (oc_q != OcLast) begin
                                oc_d = oc_q + 1'b1;
                            end else begin
                                state_d = StDone;
                            end
                        end
                    end
                end
            end
            StDone: begin
                flag    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            oc_q        <= '0;
            oh_q        <= '0;
            ow_q        <= '0;
            ic_q        <= '0;
            kr_q        <= '0;
            kc_q        <= '0;
            bias_load_q <= 1'b0;
            tap_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            oc_q        <= oc_d;
            oh_q        <= oh_d;
            ow_q        <= ow_d;
            ic_q        <= ic_d;
            kr_q        <= kr_d;
            kc_q        <= kc_d;
            bias_load_q <= (state_q == StBias);
            // Padding taps never enable the accumulator, so they add exactly zero.
            tap_en_q    <= (state_q == StMac) && tap_in_range;
        end
    end

    sm_mac #(
        .N (N),
        .Q (Q)
    ) u_sm_mac (
        .clock    (clock),
        .reset    (reset),
        .load     (bias_load_q),
        .load_val (bias_data),
        .en       (tap_en_q),
        .a        (in_data),
        .b        (w_data),
        .acc      (acc)
    );

    assign out_data = acc;
    assign out_ch   = oc_q;
    assign out_row  = oh_q;
    assign out_col  = ow_q;

endmodule

// File: tb/tb_conv2d_seq.sv
module tb_conv2d_seq;

    localparam int unsigned N = 35;

    localparam logic [N-1:0] One     = 35'h1_0000_0000;
    localparam logic [N-1:0] Half    = 35'h0_8000_0000;
    localparam logic [N-1:0] NegHalf = 35'h4_8000_0000;
    localparam logic [N-1:0] Quarter = 35'h0_4000_0000;
    localparam logic [N-1:0] PosMax  = 35'h3_FFFF_FFFF;
    localparam logic [N-1:0] NegMax  = 35'h7_FFFF_FFFF;
    localparam logic [N-1:0] Sixty4th = 35'h0_0400_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Small instance: IC=1 OC=1 4x4, K=3 S=1 P=1
    logic         s_reset, s_go, s_busy, s_flag, s_out_valid, s_out_ready;
    logic [3:0]   s_in_addr, s_w_addr;
    logic [0:0]   s_bias_addr, s_out_ch;
    logic [1:0]   s_out_row, s_out_col;
    logic [N-1:0] s_in_data, s_w_data, s_bias_data, s_out_data;
    logic [N-1:0] s_in_mem [16];
    logic [N-1:0] s_w_mem  [16];
    logic [N-1:0] s_b_mem  [2];

    always @(posedge clk) begin
        s_in_data   <= s_in_mem[s_in_addr];
        s_w_data    <= s_w_mem[s_w_addr];
        s_bias_data <= s_b_mem[s_bias_addr];
    end

    conv2d_seq #(
        .N(35), .Q(32), .IC(1), .OC(1), .H(4), .W(4), .K(3), .STRIDE(1), .PAD(1)
    ) u_small (
        .clock(clk), .reset(s_reset), .go(s_go), .busy(s_busy), .flag(s_flag),
        .in_addr(s_in_addr), .in_data(s_in_data), .w_addr(s_w_addr), .w_data(s_w_data),
        .bias_addr(s_bias_addr), .bias_data(s_bias_data), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .out_data(s_out_data), .out_ch(s_out_ch),
        .out_row(s_out_row), .out_col(s_out_col)
    );

    // Default-parameter instance
    logic         d_reset, d_go, d_busy, d_flag, d_out_valid, d_out_ready;
    logic [13:0]  d_in_addr;
    logic [9:0]   d_w_addr;
    logic [2:0]   d_bias_addr, d_out_ch;
    logic [4:0]   d_out_row, d_out_col;
    logic [N-1:0] d_in_data, d_w_data, d_bias_data, d_out_data;
    logic [N-1:0] d_in_mem [16384];
    logic [N-1:0] d_w_mem  [1024];
    logic [N-1:0] d_b_mem  [8];

    always @(posedge clk) begin
        d_in_data   <= d_in_mem[d_in_addr];
        d_w_data    <= d_w_mem[d_w_addr];
        d_bias_data <= d_b_mem[d_bias_addr];
    end

    conv2d_seq u_def (
        .clock(clk), .reset(d_reset), .go(d_go), .busy(d_busy), .flag(d_flag),
        .in_addr(d_in_addr), .in_data(d_in_data), .w_addr(d_w_addr), .w_data(d_w_data),
        .bias_addr(d_bias_addr), .bias_data(d_bias_data), .out_valid(d_out_valid),
        .out_ready(d_out_ready), .out_data(d_out_data), .out_ch(d_out_ch),
        .out_row(d_out_row), .out_col(d_out_col)
    );

    // Captured small-instance outputs
    logic [N-1:0] got_data [$];
    int           got_pos  [$];

    // Identity-test pixel i: magnitude (i+1)/8, odd pixels negative.
    function automatic logic [N-1:0] id_val(input int i);
        logic [N-1:0] v;
        v        = N'(i + 1) << 29;
        v[N-1]   = (i % 2 == 1);
        return v;
    endfunction

    task automatic load_identity();
        for (int i = 0; i < 16; i++) begin
            s_in_mem[i] = id_val(i);
            s_w_mem[i]  = (i == 4) ? One : '0;
        end
        s_b_mem[0] = '0;
        s_b_mem[1] = '0;
    endtask

    // Runs one small frame; collects accepted outputs, counts flags and stall violations.
    task automatic run_small(input int duty, input bit go_again, output int n_flag,
                             output int unstable, output bit timed_out);
        logic         held_valid;
        logic [N-1:0] held_data;
        int           post;
        got_data.delete();
        got_pos.delete();
        n_flag     = 0;
        unstable   = 0;
        timed_out  = 1'b1;
        held_valid = 1'b0;
        held_data  = '0;
        post       = 0;
        @(negedge clk);
        s_go = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            s_go = go_again && (cyc == 20);
            if (held_valid && (!s_out_valid || s_out_data !== held_data)) unstable++;
            if (s_flag) n_flag++;
            s_out_ready = ($urandom_range(99) < duty);
            if (s_out_valid && s_out_ready) begin
                got_data.push_back(s_out_data);
                got_pos.push_back(int'({s_out_ch, s_out_row, s_out_col}));
            end
            held_valid = s_out_valid && !s_out_ready;
            held_data  = s_out_data;
            if (n_flag > 0) begin
                post++;
                if (post > 4) begin
                    timed_out = 1'b0;
                    break;
                end
            end
        end
        s_go        = 1'b0;
        s_out_ready = 1'b1;
    endtask

    task automatic test_reset();
        s_reset = 1'b1; d_reset = 1'b1;
        s_go = 1'b0; d_go = 1'b0; s_out_ready = 1'b1; d_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({s_busy, s_flag, s_out_valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_small_ctrl: got %b want 000", {s_busy, s_flag, s_out_valid});
        end
        vectors++;
        if ({s_out_data, s_out_ch, s_out_row, s_out_col} !== '0) begin
            miscompares++;
            $display("FAIL reset_small_out: got %h want 0", s_out_data);
        end
        vectors++;
        if ({s_in_addr, s_w_addr, s_bias_addr} !== '0) begin
            miscompares++;
            $display("FAIL reset_small_addr: got %h want 0", {s_in_addr, s_w_addr, s_bias_addr});
        end
        vectors++;
        if ({d_busy, d_flag, d_out_valid, d_out_data, d_out_ch, d_out_row, d_out_col,
             d_in_addr, d_w_addr, d_bias_addr} !== '0) begin
            miscompares++;
            $display("FAIL reset_default: got busy=%b valid=%b data=%h want all 0",
                     d_busy, d_out_valid, d_out_data);
        end
        s_reset = 1'b0; d_reset = 1'b0;
    endtask

    task automatic test_identity();
        int n_flag, unstable;
        bit to;
        load_identity();
        run_small(100, 1'b0, n_flag, unstable, to);
        vectors++;
        if (to || got_data.size() != 16) begin
            miscompares++;
            $display("FAIL identity_count: got %0d outputs (timeout=%0d) want 16",
                     got_data.size(), to);
        end
        for (int i = 0; i < 16; i++) begin
            logic [N-1:0] gd;
            int gp;
            gd = (i < got_data.size()) ? got_data[i] : 'x;
            gp = (i < got_pos.size()) ? got_pos[i] : -1;
            vectors++;
            if (gd !== id_val(i) || gp != i) begin
                miscompares++;
                $display("FAIL identity_out%0d: got %h pos %0d want %h pos %0d",
                         i, gd, gp, id_val(i), i);
            end
        end
        vectors++;
        if (n_flag != 1) begin
            miscompares++;
            $display("FAIL identity_flag: got %0d pulses want 1", n_flag);
        end
    endtask

    task automatic test_go_while_busy();
        int n_flag, unstable;
        bit to;
        load_identity();
        run_small(100, 1'b1, n_flag, unstable, to);
        vectors++;
        if (to || got_data.size() != 16 || n_flag != 1) begin
            miscompares++;
            $display("FAIL go_while_busy: got %0d outputs %0d flags want 16 and 1",
                     got_data.size(), n_flag);
        end
        vectors++;
        if (got_data.size() > 15 && got_data[15] !== id_val(15)) begin
            miscompares++;
            $display("FAIL go_while_busy_last: got %h want %h", got_data[15], id_val(15));
        end
    endtask

    task automatic test_signed();
        int n_flag, unstable;
        bit to;
        for (int i = 0; i < 16; i++) begin
            s_in_mem[i] = NegHalf;
            s_w_mem[i]  = (i == 4) ? Half : '0;
        end
        s_b_mem[0] = Quarter;
        run_small(100, 1'b0, n_flag, unstable, to);
        vectors++;
        if (to || got_data.size() != 16) begin
            miscompares++;
            $display("FAIL signed_count: got %0d outputs want 16", got_data.size());
        end
        // -0.5 * 0.5 + 0.25 must be +0, never sign-only.
        for (int i = 0; i < 16; i += 5) begin
            logic [N-1:0] gd;
            gd = (i < got_data.size()) ? got_data[i] : 'x;
            vectors++;
            if (gd !== '0) begin
                miscompares++;
                $display("FAIL signed_zero%0d: got %h want 000000000", i, gd);
            end
        end
    endtask

    task automatic test_saturation();
        int n_flag, unstable;
        bit to;
        for (int i = 0; i < 16; i++) begin
            s_in_mem[i] = PosMax;
            s_w_mem[i]  = NegMax;
        end
        s_b_mem[0] = '0;
        run_small(100, 1'b0, n_flag, unstable, to);
        for (int i = 0; i < 16; i += 5) begin
            logic [N-1:0] gd;
            gd = (i < got_data.size()) ? got_data[i] : 'x;
            vectors++;
            if (gd !== NegMax) begin
                miscompares++;
                $display("FAIL saturate%0d: got %h want %h", i, gd, NegMax);
            end
        end
    endtask

    task automatic test_backpressure();
        int n_flag, unstable;
        bit to;
        int bad;
        load_identity();
        run_small(30, 1'b0, n_flag, unstable, to);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (i >= got_data.size() || got_data[i] !== id_val(i) || got_pos[i] != i) bad++;
        end
        vectors++;
        if (to || got_data.size() != 16 || bad != 0) begin
            miscompares++;
            $display("FAIL backpressure_seq: got %0d outputs %0d wrong want 16 and 0",
                     got_data.size(), bad);
        end
        vectors++;
        if (unstable != 0) begin
            miscompares++;
            $display("FAIL backpressure_stable: got %0d changes while stalled want 0", unstable);
        end
        vectors++;
        if (n_flag != 1) begin
            miscompares++;
            $display("FAIL backpressure_flag: got %0d pulses want 1", n_flag);
        end
    endtask

    task automatic test_reset_mid();
        int n_flag, unstable, seen;
        bit to;
        load_identity();
        @(negedge clk);
        s_go = 1'b1;
        @(negedge clk);
        s_go = 1'b0;
        s_out_ready = 1'b1;
        repeat (99) @(negedge clk);
        s_reset = 1'b1;
        @(negedge clk);
        vectors++;
        if ({s_busy, s_flag, s_out_valid, s_out_data, s_out_ch, s_out_row, s_out_col,
             s_in_addr, s_w_addr, s_bias_addr} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: got busy=%b valid=%b data=%h row=%0d col=%0d want 0",
                     s_busy, s_out_valid, s_out_data, s_out_row, s_out_col);
        end
        s_reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (s_flag || s_out_valid) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL reset_mid_quiet: got %0d flag/valid cycles want 0", seen);
        end
        run_small(100, 1'b0, n_flag, unstable, to);
        seen = 0;
        for (int i = 0; i < 16; i++) begin
            if (i >= got_data.size() || got_data[i] !== id_val(i)) seen++;
        end
        vectors++;
        if (to || got_data.size() != 16 || seen != 0 || n_flag != 1) begin
            miscompares++;
            $display("FAIL reset_mid_rerun: got %0d outputs %0d wrong %0d flags want 16 0 1",
                     got_data.size(), seen, n_flag);
        end
    endtask

    task automatic test_padding();
        logic [N-1:0] dq [$];
        int           pq [$];
        int           idx [4];
        logic [N-1:0] ed  [4];
        int           ep  [4];
        // 1.0 weights would saturate with 2 integer bits; 1/64 keeps sums exact.
        for (int i = 0; i < 16384; i++) d_in_mem[i] = One;
        for (int i = 0; i < 1024; i++)  d_w_mem[i]  = Sixty4th;
        for (int i = 0; i < 8; i++)     d_b_mem[i]  = '0;
        idx[0] = 0;  ed[0] = 35'h0_9000_0000; ep[0] = 0;        // 36 taps
        idx[1] = 1;  ed[1] = 35'h0_F000_0000; ep[1] = 1;        // 60 taps
        idx[2] = 32; ed[2] = 35'h0_F000_0000; ep[2] = 32;       // 60 taps
        idx[3] = 66; ed[3] = 35'h1_9000_0000; ep[3] = 2 * 32 + 2; // 100 taps
        @(negedge clk);
        d_go = 1'b1;
        d_out_ready = 1'b1;
        for (int cyc = 0; cyc < 9000 && dq.size() < 67; cyc++) begin
            @(negedge clk);
            d_go = 1'b0;
            if (d_out_valid && d_out_ready) begin
                dq.push_back(d_out_data);
                pq.push_back(int'(d_out_ch) * 1024 + int'(d_out_row) * 32 + int'(d_out_col));
            end
        end
        for (int k = 0; k < 4; k++) begin
            logic [N-1:0] gd;
            int gp;
            gd = (idx[k] < dq.size()) ? dq[idx[k]] : 'x;
            gp = (idx[k] < pq.size()) ? pq[idx[k]] : -1;
            vectors++;
            if (gd !== ed[k] || gp != ep[k]) begin
                miscompares++;
                $display("FAIL padding_out%0d: got %h pos %0d want %h pos %0d",
                         idx[k], gd, gp, ed[k], ep[k]);
            end
        end
        d_reset = 1'b1;
        @(negedge clk);
        d_reset = 1'b0;
        vectors++;
        if ({d_busy, d_out_valid, d_flag} !== 3'b000) begin
            miscompares++;
            $display("FAIL padding_abort: got %b want 000", {d_busy, d_out_valid, d_flag});
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_go_while_busy();
        test_signed();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        test_padding();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
